weight_stream_loader: RTL and testbench
=======================================

// Module: weight_stream_loader
// PURPOSE
//  Generic successor to the per-block fixed weight loaders. Streams one output channel at a time
//  from an external weight ROM (4..N packed weights per word) into a LANES-wide weight bus for the PE array.
//  Adds start/clear control, parametrised ROM read latency, double buffering and ready/valid backpressure.
//  Sits between the WeightBuffer ROM IP of a conv block and that block's PE array.
// PARAMETERS
//  W_BITS   7    bits per weight
//  WPR      4    weights per ROM word; ROM word = WPR*W_BITS
//  LANES    32   weights per output channel; LANES % WPR == 0, else $error at elaboration
//  N_OCH    64   output channels per pass
//  ROM_LAT  1    ROM read latency in cycles, 1..4
//  BEATS    derived = LANES/WPR (8); ROM depth = N_OCH*BEATS (512); ADDR_W = clog2(depth)
// PORTS
//  clk       in   1               clock, rising edge
//  rst_n     in   1               asynchronous, active-low reset
//  start     in   1               1-cycle pulse: begin a pass at ROM address 0
//  clear     in   1               synchronous abort, returns to IDLE
//  rom_en    out  1               ROM read enable, registered
//  rom_addr  out  ADDR_W          ROM address, registered
//  rom_data  in   WPR*W_BITS      ROM read data, valid ROM_LAT cycles after rom_en is sampled
//  w_flat    out  LANES*W_BITS    active channel weights; lane i = bits [i*W_BITS +: W_BITS]
//  w_valid   out  1               w_flat holds a complete channel
//  w_ready   in   1               PE array accepts the channel on (w_valid & w_ready)
//  och_idx   out  clog2(N_OCH)    channel index of w_flat
//  och_mask  out  N_OCH           thermometer code: bit k set once channel k is accepted
//  busy      out  1               pass in progress (state != IDLE)
//  done      out  1               level; set when last channel accepted; cleared by start/clear
// BEHAVIOUR
//  Reset: all outputs 0, both banks 0, state IDLE, address counter 0.
//  FSM:
//   IDLE  --start-->          FILL
//   FILL  --all BEATS issued-->  WAIT
//   WAIT  --last beat captured & active bank free--> transfer --> FILL (more channels) or DRAIN (none)
//   DRAIN --last channel accepted--> IDLE, done=1
//  Reads: one per cycle while in FILL; rom_addr increments by 1 and never wraps within a pass.
//   rom_en is low in every other state.
//  Data tracking: a ROM_LAT-deep valid/beat-index shift register tags returning data.
//  Packing: beat b writes shadow lanes b*WPR+k (k = 0..WPR-1) from
//   rom_data[(WPR-k)*W_BITS-1 -: W_BITS], i.e. first weight in the MSBs.
//  Transfer:
//   - shadow -> active in a single cycle; sets w_valid and loads och_idx.
//   - Allowed only when w_valid==0 or an accept occurs in the same cycle.
//  Accept (w_valid & w_ready): sets och_mask[och_idx]; w_valid drops unless a transfer occurs in the same cycle.
//  Prefetch: the next channel's FILL starts the cycle after a transfer, so the ROM fetch overlaps PE use.
//  Latency (defaults): w_valid asserts after edge BEATS+ROM_LAT+1 = 10, counted from the start edge.
//   Sustained rate with w_ready=1 is <= BEATS+ROM_LAT+1 cycles per channel.
//  w_flat and och_idx stay stable while w_valid=1 and w_ready=0.
//  Boundaries:
//   - start while busy: ignored.
//   - start while done=1: clears done and och_mask, restarts at address 0.
//   - clear: highest priority, any state. Flushes in-flight tags, drops w_valid, sets state IDLE and addr 0.
//     Keeps och_mask and w_flat contents; done=0.
//   - start and clear in the same cycle: clear wins.
//   - rst_n asserted mid-pass: immediate return to reset values.
// STRUCTURE
//  Shared package wl_pkg: FSM state encoding (IDLE, FILL, WAIT, DRAIN) and a clog2 function.
//   Per-block parameter sets (B1..B5: LANES, N_OCH, WPR) are defined there as constants.
//  One sub-module, wl_lat_pipe: ROM_LAT-deep shift register of {valid, beat_idx}, with synchronous flush.
//  The ROM IP is instantiated by the parent, not inside this block.
// TESTING
//  1. Defaults, w_ready=1, ROM word[a]=a:
//     - rom_addr sweeps 0..511 exactly once;
//     - och k lanes 4b..4b+3 equal {a[27:21], a[20:14], a[13:7], a[6:0]} with a=8k+b;
//     - done=1 after 64 accepts; och_mask = all ones.
//  2. Backpressure, w_ready low for 20 cycles on channel 3:
//     - w_flat/och_idx hold at 3;
//     - rom_en stops after channel 4 is in shadow;
//     - no channel lost or duplicated.
//  3. ROM_LAT=3, LANES=16, N_OCH=8:
//     - first w_valid after edge 4+3+1=8;
//     - 32 reads total; lane data correct.
//  4. start pulsed at cycle 5 of a pass: ignored, addresses continue unchanged.
//     start after done: done=0 and och_mask=0 next cycle, address restarts at 0.
//  5. clear in FILL of channel 10 with 2 reads in flight:
//     - w_valid=0 and busy=0 next cycle;
//     - stale data is not written;
//     - a new start yields channel 0 with correct data.
//  6. rst_n asserted mid-pass: all outputs return to 0 asynchronously. After release, behaviour matches scenario 1.

Source files
------------

// File: rtl/wl_pkg.sv
// Shared types and helpers for the weight stream loaders: FSM encoding, clog2,
// and the parameter sets of the individual conv blocks.
package wl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Ceiling log2, never narrower than one bit so it can size any port.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

    localparam int B1_LANES = 32;  localparam int B1_N_OCH = 64;  localparam int B1_WPR = 4;
    localparam int B2_LANES = 64;  localparam int B2_N_OCH = 64;  localparam int B2_WPR = 4;
    localparam int B3_LANES = 64;  localparam int B3_N_OCH = 128; localparam int B3_WPR = 8;
    localparam int B4_LANES = 128; localparam int B4_N_OCH = 128; localparam int B4_WPR = 8;
    localparam int B5_LANES = 128; localparam int B5_N_OCH = 256; localparam int B5_WPR = 8;

endpackage

// File: rtl/wl_lat_pipe.sv
// Tag pipeline matching the ROM read latency: carries {valid, beat index} of each
// issued read so returning data can be steered into the right shadow lanes.
module wl_lat_pipe #(
    parameter int DEPTH  = 1,
    parameter int BEAT_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [BEAT_W-1:0] in_beat,
    output logic              out_valid,
    output logic [BEAT_W-1:0] out_beat
);

    logic [DEPTH-1:0]  valid_q;
    logic [BEAT_W-1:0] beat_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) beat_q[i] <= '0;
        end else if (flush) begin
            // Only the valid bits matter; stale beat indices are never used.
            valid_q <= '0;
        end else begin
            valid_q[0] <= in_valid;
            beat_q[0]  <= in_beat;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                beat_q[i]  <= beat_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_beat  = beat_q[DEPTH-1];

endmodule

// File: rtl/weight_stream_loader.sv
// Streams one output channel at a time from a packed weight ROM into a LANES-wide,
// double-buffered weight bus with ready/valid handshake towards the PE array.
module weight_stream_loader
    import wl_pkg::*;
#(
    parameter int  W_BITS  = 7,
    parameter int  WPR     = 4,
    parameter int  LANES   = 32,
    parameter int  N_OCH   = 64,
    parameter int  ROM_LAT = 1,
    localparam int BEATS   = LANES / WPR,
    localparam int ADDR_W  = clog2(N_OCH * BEATS),
    localparam int OCH_W   = clog2(N_OCH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    clear,
    output logic                    rom_en,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [WPR*W_BITS-1:0]   rom_data,
    output logic [LANES*W_BITS-1:0] w_flat,
    output logic                    w_valid,
    input  logic                    w_ready,
    output logic [OCH_W-1:0]        och_idx,
    output logic [N_OCH-1:0]        och_mask,
    output logic                    busy,
    output logic                    done
);

    localparam int BEAT_W = clog2(BEATS);
    localparam int BCNT_W = clog2(BEATS + 1);

    if (LANES % WPR != 0) begin : g_lanes_check
        $error("weight_stream_loader: LANES (%0d) must be a multiple of WPR (%0d)", LANES, WPR);
    end
    if (ROM_LAT < 1 || ROM_LAT > 4) begin : g_lat_check
        $error("weight_stream_loader: ROM_LAT (%0d) must be within 1..4", ROM_LAT);
    end

    state_t                  state;
    logic [ADDR_W-1:0]       addr_cnt;
    logic [BCNT_W-1:0]       beat_cnt;
    logic [BEAT_W-1:0]       rom_beat;
    logic [OCH_W-1:0]        fill_och;
    logic                    shadow_full;
    logic [LANES*W_BITS-1:0] shadow;
    logic                    tag_valid;
    logic [BEAT_W-1:0]       tag_beat;
    logic                    accept;
    logic                    xfer;

    wl_lat_pipe #(
        .DEPTH  (ROM_LAT),
        .BEAT_W (BEAT_W)
    ) u_lat_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (clear),
        .in_valid  (rom_en),
        .in_beat   (rom_beat),
        .out_valid (tag_valid),
        .out_beat  (tag_beat)
    );

    assign accept = w_valid & w_ready;
    // The active bank is free when empty or being drained in this very cycle.
    assign xfer   = (state == WAIT) & shadow_full & (~w_valid | accept);
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: both weight banks are reset so w_flat is defined from the first cycle.
            state       <= IDLE;
            rom_en      <= 1'b0;
            rom_addr    <= '0;
            rom_beat    <= '0;
            addr_cnt    <= '0;
            beat_cnt    <= '0;
            fill_och    <= '0;
            shadow_full <= 1'b0;
            shadow      <= '0;
            w_flat      <= '0;
            w_valid     <= 1'b0;
            och_idx     <= '0;
            och_mask    <= '0;
            done        <= 1'b0;
        end else if (clear) begin
            // NOTE: clear outranks start and every state transition; banks and och_mask are kept.
            state       <= IDLE;
            rom_en      <= 1'b0;
            rom_addr    <= '0;
            addr_cnt    <= '0;
            beat_cnt    <= '0;
            fill_och    <= '0;
            shadow_full <= 1'b0;
            w_valid     <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (accept) begin
                och_mask[och_idx] <= 1'b1;
                w_valid           <= 1'b0;
            end

            if (tag_valid) begin
                // First weight of the ROM word sits in its MSBs.
                for (int k = 0; k < WPR; k++) begin
                    shadow[(int'(tag_beat) * WPR + k) * W_BITS +: W_BITS] <=
                        rom_data[(WPR - k) * W_BITS - 1 -: W_BITS];
                end
                if (tag_beat == BEAT_W'(BEATS - 1)) shadow_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FILL;
                        done     <= 1'b0;
                        och_mask <= '0;
                        fill_och <= '0;
                        rom_en   <= 1'b1;
                        rom_addr <= '0;
                        rom_beat <= '0;
                        addr_cnt <= ADDR_W'(1);
                        beat_cnt <= BCNT_W'(1);
                    end
                end
                FILL: begin
                    if (beat_cnt == BCNT_W'(BEATS)) begin
                        rom_en <= 1'b0;
                        state  <= WAIT;
                    end else begin
                        rom_en   <= 1'b1;
                        rom_addr <= addr_cnt;
                        rom_beat <= beat_cnt[BEAT_W-1:0];
                        addr_cnt <= addr_cnt + 1'b1;
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (xfer) begin
                        w_flat      <= shadow;
                        och_idx     <= fill_och;
                        w_valid     <= 1'b1;
                        shadow_full <= 1'b0;
                        fill_och    <= fill_och + 1'b1;
                        if (fill_och == OCH_W'(N_OCH - 1)) begin
                            state <= DRAIN;
                        end else begin
                            // Prefetch the next channel while the PE array uses this one.
                            state    <= FILL;
                            rom_en   <= 1'b1;
                            rom_addr <= addr_cnt;
                            rom_beat <= '0;
                            addr_cnt <= addr_cnt + 1'b1;
                            beat_cnt <= BCNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_stream_loader.sv
// Directed bench for weight_stream_loader: a default instance and a ROM_LAT=3,
// LANES=16, N_OCH=8 instance, each with a ROM model, address monitor and scoreboard.
module tb_weight_stream_loader;

    typedef struct {
        int           och;
        logic [223:0] flat;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic         start_a = 1'b0, clear_a = 1'b0, w_ready_a = 1'b1;
    logic         rom_en_a, w_valid_a, busy_a, done_a;
    logic [8:0]   rom_addr_a;
    logic [27:0]  rom_data_a;
    logic [223:0] w_flat_a;
    logic [5:0]   och_idx_a;
    logic [63:0]  och_mask_a;

    logic         start_b = 1'b0, clear_b = 1'b0, w_ready_b = 1'b1;
    logic         rom_en_b, w_valid_b, busy_b, done_b;
    logic [4:0]   rom_addr_b;
    logic [27:0]  rom_data_b;
    logic [111:0] w_flat_b;
    logic [2:0]   och_idx_b;
    logic [7:0]   och_mask_b;

    int   n_vec = 0;
    int   n_err = 0;
    int   exp_addr_a = 0, reads_a = 0, exp_addr_b = 0, reads_b = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];

    always #5 clk = ~clk;

    weight_stream_loader dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .clear(clear_a),
        .rom_en(rom_en_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .w_flat(w_flat_a), .w_valid(w_valid_a), .w_ready(w_ready_a),
        .och_idx(och_idx_a), .och_mask(och_mask_a), .busy(busy_a), .done(done_a)
    );

    weight_stream_loader #(.LANES(16), .N_OCH(8), .ROM_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .clear(clear_b),
        .rom_en(rom_en_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .w_flat(w_flat_b), .w_valid(w_valid_b), .w_ready(w_ready_b),
        .och_idx(och_idx_b), .och_mask(och_mask_b), .busy(busy_b), .done(done_b)
    );

    function automatic logic [27:0] rom_word(input int a, input bit hashed);
        logic [31:0] h;
        h = a * 32'h9E3779B1 + 32'h01234567;
        return hashed ? h[27:0] : 28'(a);
    endfunction

    // Lane i of channel c comes from word c*(lanes/4)+i/4, field i%4 counted from the MSB end.
    function automatic logic [223:0] exp_flat(input int och, input int lanes, input bit hashed);
        logic [223:0] f;
        logic [27:0]  w;
        f = '0;
        for (int i = 0; i < lanes; i++) begin
            w = rom_word(och * (lanes / 4) + i / 4, hashed);
            f[i*7 +: 7] = 7'(w >> ((3 - i % 4) * 7));
        end
        return f;
    endfunction

    // ROM models: one-cycle and three-cycle read latency.
    logic [27:0] rb [3];
    always @(posedge clk) begin
        if (rom_en_a) rom_data_a <= rom_word(int'(rom_addr_a), 1'b0);
        if (rom_en_b) rb[0] <= rom_word(int'(rom_addr_b), 1'b1);
        rb[1] <= rb[0];
        rb[2] <= rb[1];
    end
    assign rom_data_b = rb[2];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitors sample 1 time unit after the falling edge, after the bench has driven inputs.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rst_n && rom_en_a) begin
            check("rom_addr_a", 256'(rom_addr_a), 256'(exp_addr_a));
            exp_addr_a++;
            reads_a++;
        end
        if (rst_n && w_valid_a && w_ready_a) begin
            if (sb_a.size() == 0) check("sb_a_unexpected", 256'(w_valid_a), 256'(0));
            else begin
                e = sb_a.pop_front();
                check("och_idx_a", 256'(och_idx_a), 256'(e.och));
                check("w_flat_a", 256'(w_flat_a), 256'(e.flat));
            end
        end
        if (rst_n && rom_en_b) begin
            check("rom_addr_b", 256'(rom_addr_b), 256'(exp_addr_b));
            exp_addr_b++;
            reads_b++;
        end
        if (rst_n && w_valid_b && w_ready_b) begin
            if (sb_b.size() == 0) check("sb_b_unexpected", 256'(w_valid_b), 256'(0));
            else begin
                e = sb_b.pop_front();
                check("och_idx_b", 256'(och_idx_b), 256'(e.och));
                check("w_flat_b", 256'(w_flat_b), 256'(e.flat));
            end
        end
    end

    task automatic start_pass_a();
        exp_t e;
        sb_a.delete();
        for (int c = 0; c < 64; c++) begin
            e.och  = c;
            e.flat = exp_flat(c, 32, 1'b0);
            sb_a.push_back(e);
        end
        exp_addr_a = 0;
        reads_a    = 0;
        start_a    = 1'b1;
        @(negedge clk);
        start_a    = 1'b0;
    endtask

    // Called right after start_pass_a; w_valid must first rise after edge 10.
    task automatic latency_a(input bit poke_start);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check($sformatf("latency_a_edge%0d", i), 256'(w_valid_a), 256'(i == 10));
            start_a = poke_start && (i == 5);
        end
        start_a = 1'b0;
    endtask

    task automatic finish_pass_a();
        int n;
        n = 0;
        while (!done_a && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("done_a", 256'(done_a), 256'(1));
        check("busy_a_end", 256'(busy_a), 256'(0));
        check("och_mask_a_full", 256'(och_mask_a), 256'({64{1'b1}}));
        check("reads_a", 256'(reads_a), 256'(512));
        check("sb_a_left", 256'(sb_a.size()), 256'(0));
    endtask

    initial begin
        exp_t e;
        int   n;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rom_en", 256'(rom_en_a), 256'(0));
        check("rst_rom_addr", 256'(rom_addr_a), 256'(0));
        check("rst_w_valid", 256'(w_valid_a), 256'(0));
        check("rst_w_flat", 256'(w_flat_a), 256'(0));
        check("rst_och_idx", 256'(och_idx_a), 256'(0));
        check("rst_och_mask", 256'(och_mask_a), 256'(0));
        check("rst_busy", 256'(busy_a), 256'(0));
        check("rst_done", 256'(done_a), 256'(0));
        check("rst_w_flat_b", 256'(w_flat_b), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Full pass, defaults; a start at cycle 5 must be ignored
        start_pass_a();
        check("busy_a_start", 256'(busy_a), 256'(1));
        latency_a(1'b1);
        finish_pass_a();

        // Restart after done, then backpressure on channel 3
        start_pass_a();
        check("done_a_cleared", 256'(done_a), 256'(0));
        check("och_mask_a_cleared", 256'(och_mask_a), 256'(0));
        check("restart_rom_en", 256'(rom_en_a), 256'(1));
        check("restart_rom_addr", 256'(rom_addr_a), 256'(0));
        n = 0;
        while (!(w_valid_a && och_idx_a == 6'd3) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("och3_seen", 256'(och_idx_a), 256'(3));
        w_ready_a = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check("hold_valid", 256'(w_valid_a), 256'(1));
            check("hold_och", 256'(och_idx_a), 256'(3));
            check("hold_flat", 256'(w_flat_a), 256'(exp_flat(3, 32, 1'b0)));
        end
        check("bp_rom_en", 256'(rom_en_a), 256'(0));
        check("bp_reads", 256'(reads_a), 256'(40));
        w_ready_a = 1'b1;
        finish_pass_a();

        // Clear during FILL of channel 10
        start_pass_a();
        n = 0;
        while (!(rom_en_a && rom_addr_a == 9'd82) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("clear_point", 256'(rom_addr_a), 256'(82));
        clear_a = 1'b1;
        @(negedge clk);
        clear_a = 1'b0;
        sb_a.delete();
        check("clr_w_valid", 256'(w_valid_a), 256'(0));
        check("clr_busy", 256'(busy_a), 256'(0));
        check("clr_rom_en", 256'(rom_en_a), 256'(0));
        check("clr_done", 256'(done_a), 256'(0));
        check("clr_och_mask", 256'(och_mask_a), 256'(64'h3FF));
        check("clr_w_flat", 256'(w_flat_a), 256'(exp_flat(9, 32, 1'b0)));
        repeat (6) begin
            @(negedge clk);
            check("clr_quiet", 256'(w_valid_a), 256'(0));
        end
        start_pass_a();
        latency_a(1'b0);
        finish_pass_a();

        // Asynchronous reset mid-pass
        start_pass_a();
        repeat (100) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_rom_en", 256'(rom_en_a), 256'(0));
        check("arst_rom_addr", 256'(rom_addr_a), 256'(0));
        check("arst_w_valid", 256'(w_valid_a), 256'(0));
        check("arst_w_flat", 256'(w_flat_a), 256'(0));
        check("arst_och_idx", 256'(och_idx_a), 256'(0));
        check("arst_och_mask", 256'(och_mask_a), 256'(0));
        check("arst_busy", 256'(busy_a), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        sb_a.delete();
        @(negedge clk);
        start_pass_a();
        latency_a(1'b0);
        finish_pass_a();

        // ROM_LAT=3, LANES=16, N_OCH=8 instance
        sb_b.delete();
        for (int c = 0; c < 8; c++) begin
            e.och  = c;
            e.flat = exp_flat(c, 16, 1'b1);
            sb_b.push_back(e);
        end
        exp_addr_b = 0;
        reads_b    = 0;
        start_b    = 1'b1;
        @(negedge clk);
        start_b    = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check($sformatf("latency_b_edge%0d", i), 256'(w_valid_b), 256'(i == 8));
        end
        n = 0;
        while (!done_b && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("done_b", 256'(done_b), 256'(1));
        check("reads_b", 256'(reads_b), 256'(32));
        check("och_mask_b_full", 256'(och_mask_b), 256'(8'hFF));
        check("sb_b_left", 256'(sb_b.size()), 256'(0));

        // start and clear together: clear wins
        start_b = 1'b1;
        clear_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        clear_b = 1'b0;
        check("sc_busy_b", 256'(busy_b), 256'(0));
        check("sc_rom_en_b", 256'(rom_en_b), 256'(0));
        check("sc_done_b", 256'(done_b), 256'(0));
        check("sc_mask_b_kept", 256'(och_mask_b), 256'(8'hFF));

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

endmodule
